// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
//
// Single-clock FIFO pointer controller. Accepts push/pop requests, drives the
// write/read enables and addresses of an external 2**ADDR_W-entry storage
// array, tracks occupancy with a three-state EMPTY/PARTIAL/FULL machine, and
// exports registered gray-coded pointers so the same block can later be split
// across clock domains.
//
// Ports
//   clk           clock, all logic on rising edge
//   rst           synchronous active-high reset
//   push / pop    write / read requests
//   clr_err       clears the sticky overflow/underflow flags
//   wr_en/wr_addr array write strobe (accepted push) and address
//   rd_en/rd_addr array read strobe (accepted pop) and address; the array owns
//                 read data, this block adds no read latency
//   wr_ptr_gray   gray-coded write pointer (ADDR_W+1 bits)
//   rd_ptr_gray   gray-coded read pointer  (ADDR_W+1 bits)
//   level         occupancy, 0..DEPTH
//   full/empty    decoded from the state machine
//   almost_full   level >= AFULL_TH
//   almost_empty  level <= AEMPTY_TH
//   overflow      sticky: push seen while full
//   underflow     sticky: pop seen while empty
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  // One extra pointer bit distinguishes a full FIFO from an empty one when the
  // address bits of both pointers coincide.
  localparam int PTR_W = ADDR_W + 1;

  localparam logic [PTR_W-1:0] DEPTH_LV  = PTR_W'(1 << ADDR_W);
  localparam logic [PTR_W-1:0] ONE_LV    = PTR_W'(1);
  localparam logic [PTR_W-1:0] AFULL_LV  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_LV = PTR_W'(AEMPTY_TH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptrNext;
  logic [PTR_W-1:0] rptrNext;
  logic [PTR_W-1:0] levelNext;

  // Flags come straight from registered state, so acceptance never depends
  // combinationally on this cycle's requests beyond the final AND.
  assign full    = (state == ST_FULL);
  assign empty   = (state == ST_EMPTY);
  assign wr_en   = push & ~full;
  assign rd_en   = pop  & ~empty;
  assign wr_addr = wptr[ADDR_W-1:0];
  assign rd_addr = rptr[ADDR_W-1:0];

  // Pointer arithmetic wraps naturally at PTR_W bits; the occupancy is the
  // modular difference, which equals +1/-1/0 relative to the current level.
  always_comb begin
    wptrNext  = wptr + PTR_W'(wr_en);
    rptrNext  = rptr + PTR_W'(rd_en);
    levelNext = wptrNext - rptrNext;
  end

  // NOTE: every signal written in a combinational block is given a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    case (state)
      ST_EMPTY: begin
        if (wr_en) stateNext = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (wr_en && !rd_en && level == DEPTH_LV - ONE_LV) begin
          stateNext = ST_FULL;
        end else if (rd_en && !wr_en && level == ONE_LV) begin
          stateNext = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (rd_en) stateNext = ST_PARTIAL;
      end
      default: stateNext = ST_EMPTY;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      wptr         <= '0;
      rptr         <= '0;
      wr_ptr_gray  <= '0;
      rd_ptr_gray  <= '0;
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      state        <= stateNext;
      wptr         <= wptrNext;
      rptr         <= rptrNext;
      // Gray codes are taken from the next binary value so they line up with
      // the pointers in the same cycle and step by exactly one bit per op.
      wr_ptr_gray  <= wptrNext ^ (wptrNext >> 1);
      rd_ptr_gray  <= rptrNext ^ (rptrNext >> 1);
      level        <= levelNext;
      almost_full  <= (levelNext >= AFULL_LV);
      almost_empty <= (levelNext <= AEMPTY_LV);
      // A fresh error in the same cycle as clr_err keeps the flag set.
      overflow     <= (overflow  & ~clr_err) | (push & full);
      underflow    <= (underflow & ~clr_err) | (pop  & empty);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
module tb_fifo_ptr_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   wr_ptr_gray, rd_ptr_gray, level;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  fifo_ptr_ctrl #(.ADDR_W(AW), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .level(level),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: total items ever written/read as plain integers.
  int mW = 0, mR = 0;
  bit mOvf = 0, mUdf = 0;

  // Combinational outputs sampled before the edge of the last cycle.
  logic          aWrEn, aRdEn;
  logic [AW-1:0] aWrAddr, aRdAddr;

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, compare everything against the model, then advance it.
  task automatic cycle(input logic r, input logic p, input logic q, input logic c,
                       input bit chkComb);
    int  lvl;
    bit  wa, ra;
    @(negedge clk);
    rst = r; push = p; pop = q; clr_err = c;
    #1;
    lvl = mW - mR;
    wa  = p && (lvl < DEPTH);
    ra  = q && (lvl > 0);
    aWrEn = wr_en; aRdEn = rd_en; aWrAddr = wr_addr; aRdAddr = rd_addr;
    if (chkComb) begin
      check("m.wr_en",   wr_en,   wa);
      check("m.rd_en",   rd_en,   ra);
      check("m.wr_addr", wr_addr, mW % DEPTH);
      check("m.rd_addr", rd_addr, mR % DEPTH);
    end
    @(posedge clk);
    #1;
    if (r) begin
      mW = 0; mR = 0; mOvf = 0; mUdf = 0;
    end else begin
      mOvf = (mOvf && !c) || (p && lvl == DEPTH);
      mUdf = (mUdf && !c) || (q && lvl == 0);
      mW += int'(wa);
      mR += int'(ra);
    end
    lvl = mW - mR;
    check("m.level",        level,        lvl);
    check("m.wr_ptr_gray",  wr_ptr_gray,  gray(mW));
    check("m.rd_ptr_gray",  rd_ptr_gray,  gray(mR));
    check("m.full",         full,         lvl == DEPTH);
    check("m.empty",        empty,        lvl == 0);
    check("m.almost_full",  almost_full,  lvl >= 6);
    check("m.almost_empty", almost_empty, lvl <= 2);
    check("m.overflow",     overflow,     mOvf);
    check("m.underflow",    underflow,    mUdf);
  endtask

  typedef struct {
    logic rst, push, pop, clr;
    logic wrEn, rdEn;
    int          level;
    logic [AW:0] wg, rg;
    logic full, empty, af, ae, ov, ud;
  } vecT;

  function automatic vecT mk(input logic r, p, q, c, we, re, input int lv,
                             input logic [AW:0] wg, rg,
                             input logic f, e, af, ae, ov, ud);
    vecT v;
    v.rst = r; v.push = p; v.pop = q; v.clr = c; v.wrEn = we; v.rdEn = re;
    v.level = lv; v.wg = wg; v.rg = rg;
    v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ov = ov; v.ud = ud;
    return v;
  endfunction

  vecT tbl[18];
  logic [AW:0] wgTab[8];

  initial begin
    logic [AW:0] gPrev;
    int pushBias, popBias;

    // Vector table starting from the reset state.
    wgTab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    tbl[0] = mk(0,0,0,0, 0,0, 0, 4'h0, 4'h0, 0,1,0,1, 0,0);
    for (int k = 1; k <= 8; k++)
      tbl[k] = mk(0,1,0,0, 1,0, k, wgTab[k-1], 4'h0, k == 8, 0, k >= 6, k <= 2, 0,0);
    tbl[9]  = mk(0,1,0,0, 0,0, 8, 4'hC, 4'h0, 1,0,1,0, 1,0);  // push while full
    tbl[10] = mk(0,0,0,1, 0,0, 8, 4'hC, 4'h0, 1,0,1,0, 0,0);  // clr_err
    tbl[11] = mk(0,1,1,0, 0,1, 7, 4'hC, 4'h1, 0,0,1,0, 1,0);  // push+pop while full
    tbl[12] = mk(0,0,0,1, 0,0, 7, 4'hC, 4'h1, 0,0,1,0, 0,0);
    tbl[13] = mk(1,1,0,0, 1,0, 0, 4'h0, 4'h0, 0,1,0,1, 0,0);  // reset beats push
    tbl[14] = mk(0,1,1,0, 1,0, 1, 4'h1, 4'h0, 0,0,0,1, 0,1);  // push+pop while empty
    tbl[15] = mk(0,0,1,0, 0,1, 0, 4'h1, 4'h1, 0,1,0,1, 0,1);
    tbl[16] = mk(0,0,1,1, 0,0, 0, 4'h1, 4'h1, 0,1,0,1, 0,1);  // new error beats clr
    tbl[17] = mk(0,0,0,1, 0,0, 0, 4'h1, 4'h1, 0,1,0,1, 0,0);

    cycle(1, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].clr, 1);
      check($sformatf("t%0d.wr_en", i),        aWrEn,        tbl[i].wrEn);
      check($sformatf("t%0d.rd_en", i),        aRdEn,        tbl[i].rdEn);
      check($sformatf("t%0d.level", i),        level,        tbl[i].level);
      check($sformatf("t%0d.wr_ptr_gray", i),  wr_ptr_gray,  tbl[i].wg);
      check($sformatf("t%0d.rd_ptr_gray", i),  rd_ptr_gray,  tbl[i].rg);
      check($sformatf("t%0d.full", i),         full,         tbl[i].full);
      check($sformatf("t%0d.empty", i),        empty,        tbl[i].empty);
      check($sformatf("t%0d.almost_full", i),  almost_full,  tbl[i].af);
      check($sformatf("t%0d.almost_empty", i), almost_empty, tbl[i].ae);
      check($sformatf("t%0d.overflow", i),     overflow,     tbl[i].ov);
      check($sformatf("t%0d.underflow", i),    underflow,    tbl[i].ud);
    end

    // Simultaneous push+pop at level 4: level held, both addresses advance.
    while (mW - mR < 4) cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 1);
    check("pp4.level", level, 4);
    check("pp4.wr_en", aWrEn, 1);
    check("pp4.rd_en", aRdEn, 1);

    // 20 push/pop pairs from level 3: pointers wrap, gray steps are single-bit.
    cycle(0, 0, 1, 0, 1);
    check("wrap.start_level", level, 3);
    for (int i = 0; i < 20; i++) begin
      gPrev = wr_ptr_gray;
      cycle(0, 1, 1, 0, 1);
      check("wrap.wr_gray_1bit", $countones(wr_ptr_gray ^ gPrev), 1);
    end
    check("wrap.end_level", level, 3);

    // Reset at level 5 with push asserted, with sticky flags set first.
    cycle(0, 0, 0, 1, 1);
    while (mW - mR < DEPTH) cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    while (mW - mR > 5) cycle(0, 0, 1, 0, 1);
    check("rst5.level_before", level, 5);
    check("rst5.ovf_before", overflow, 1);
    cycle(1, 1, 0, 0, 1);
    check("rst5.level", level, 0);
    check("rst5.empty", empty, 1);
    check("rst5.wr_gray", wr_ptr_gray, 0);
    check("rst5.rd_gray", rd_ptr_gray, 0);
    check("rst5.overflow", overflow, 0);

    // Randomised traffic with drifting bias so both ends get exercised.
    pushBias = 50; popBias = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        pushBias = $urandom_range(10, 90);
        popBias  = $urandom_range(10, 90);
      end
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 99) < pushBias,
            $urandom_range(0, 99) < popBias,
            $urandom_range(0, 15) == 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
